// File: rtl/pong_pkg.sv
// Types and panel geometry shared by the scan controller, the renderer and the game logic.
package pong_pkg;

  localparam int unsigned PANEL_W   = 64;
  localparam int unsigned PANEL_H   = 64;
  localparam int unsigned ROW_PAIRS = PANEL_H / 2;

  typedef logic [5:0] coord_t;
  typedef logic [4:0] row_t;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StBlank,
    StLatch,
    StDisplay
  } scan_state_e;

endpackage

// File: rtl/led_scan_timer.sv
// Loadable down-counter that stops at zero; o_done flags the last cycle of an interval.
module led_scan_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_value,
  output logic [Width-1:0] o_count,
  output logic             o_done
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// 1/32-scan LED panel controller: shift a row pair, blank, latch, then display for a fixed
// on-time. Every panel-facing output comes straight from a flop.
module led_scan_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned COLS         = 64,
  parameter int unsigned ROW_PAIRS    = 32,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned ON_CYCLES    = 256
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_enable,
  output coord_t o_pix_x,
  output coord_t o_pix_y_top,
  output coord_t o_pix_y_bot,
  input  logic   i_pix_top,
  input  logic   i_pix_bot,
  output logic   o_r_top,
  output logic   o_r_bot,
  output logic   o_sclk,
  output logic   o_lat,
  output logic   o_oe_n,
  output row_t   o_row_addr,
  output logic   o_frame_done
);

  localparam int unsigned PhaseLen = 2 * CLK_DIV;
  localparam int unsigned TmrMax0  = (ON_CYCLES > PhaseLen) ? ON_CYCLES : PhaseLen;
  localparam int unsigned TmrMax   = (BLANK_CYCLES > TmrMax0) ? BLANK_CYCLES : TmrMax0;
  localparam int unsigned TmrW     = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  localparam logic [TmrW-1:0] PhaseLast = TmrW'(PhaseLen - 1);
  localparam logic [TmrW-1:0] BlankLast = TmrW'(BLANK_CYCLES - 1);
  localparam logic [TmrW-1:0] OnLast    = TmrW'(ON_CYCLES - 1);
  localparam coord_t          LastCol   = coord_t'(COLS - 1);
  localparam row_t            LastRow   = row_t'(ROW_PAIRS - 1);

  scan_state_e     r_state;
  coord_t          r_col;
  row_t            r_row;
  logic            w_tmr_load;
  logic [TmrW-1:0] w_tmr_val;
  logic [TmrW-1:0] w_tmr_cnt;
  logic            w_tmr_done;
  logic [TmrW-1:0] w_phase;

  led_scan_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_count (w_tmr_cnt),
    .o_done  (w_tmr_done)
  );

  // The timer counts down, so the cycle index inside a column phase is its complement.
  assign w_phase     = PhaseLast - w_tmr_cnt;
  assign o_pix_y_top = {1'b0, r_row};
  assign o_pix_y_bot = {1'b1, r_row};

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = PhaseLast;
    case (r_state)
      StIdle:    w_tmr_load = i_enable;
      StShift: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          if (r_col == LastCol) w_tmr_val = BlankLast;
        end
      end
      StLatch: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = OnLast;
      end
      StDisplay: w_tmr_load = w_tmr_done & i_enable;
      default:   w_tmr_load = 1'b0;
    endcase
  end

  // Outputs are assigned the value they must show in the cycle after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      o_pix_x      <= '0;
      o_r_top      <= 1'b0;
      o_r_bot      <= 1'b0;
      o_sclk       <= 1'b0;
      o_lat        <= 1'b0;
      o_oe_n       <= 1'b1;
      o_row_addr   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_enable) begin
            r_state <= StShift;
            r_col   <= '0;
            r_row   <= '0;
            o_pix_x <= '0;
          end
        end
        StShift: begin
          // Renderer answers one cycle after the address, i.e. in phase cycle 1.
          if (w_phase == TmrW'(1)) begin
            o_r_top <= i_pix_top;
            o_r_bot <= i_pix_bot;
          end
          if (w_tmr_done) begin
            o_sclk <= 1'b0;
            if (r_col == LastCol) begin
              r_state    <= StBlank;
              o_row_addr <= r_row;
            end else begin
              r_col   <= r_col + 1'b1;
              o_pix_x <= r_col + 1'b1;
            end
          end else begin
            o_sclk <= (w_phase >= TmrW'(CLK_DIV - 1));
          end
        end
        StBlank: begin
          if (w_tmr_done) begin
            r_state <= StLatch;
            o_lat   <= 1'b1;
          end
        end
        StLatch: begin
          r_state <= StDisplay;
          o_lat   <= 1'b0;
          o_oe_n  <= 1'b0;
        end
        StDisplay: begin
          if (w_tmr_done) begin
            o_oe_n       <= 1'b1;
            o_frame_done <= (r_row == LastRow);
            r_row        <= (r_row == LastRow) ? '0 : r_row + 1'b1;
            if (i_enable) begin
              r_state <= StShift;
              r_col   <= '0;
              o_pix_x <= '0;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: cycle-index reference model plus directed per-row measurements.
module tb_led_scan_ctrl;

  localparam int COLS      = 64;
  localparam int ROW_PAIRS = 32;
  localparam int CLK_DIV   = 2;
  localparam int BLANK     = 4;
  localparam int ON        = 256;
  localparam int PH        = 2 * CLK_DIV;
  localparam int SHIFT_LEN = COLS * PH;
  localparam int LAT_O     = SHIFT_LEN + BLANK;
  localparam int DISP0     = LAT_O + 1;
  localparam int ROW_LEN   = DISP0 + ON;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [5:0] pix_x, pix_y_top, pix_y_bot;
  logic       pix_top, pix_bot;
  logic       r_top, r_bot, sclk, lat, oe_n, frame_done;
  logic [4:0] row_addr;

  int n_checks = 0;
  int n_errors = 0;
  int pattern  = 0;

  led_scan_ctrl #(
    .COLS         (COLS),
    .ROW_PAIRS    (ROW_PAIRS),
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK),
    .ON_CYCLES    (ON)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (enable),
    .o_pix_x      (pix_x),
    .o_pix_y_top  (pix_y_top),
    .o_pix_y_bot  (pix_y_bot),
    .i_pix_top    (pix_top),
    .i_pix_bot    (pix_bot),
    .o_r_top      (r_top),
    .o_r_bot      (r_bot),
    .o_sclk       (sclk),
    .o_lat        (lat),
    .o_oe_n       (oe_n),
    .o_row_addr   (row_addr),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic int rend_top(input int x, input int y);
    if (pattern == 0) return (x == 14 && y == 1) ? 1 : 0;
    return ((x + y) % 3 == 0) ? 1 : 0;
  endfunction

  function automatic int rend_bot(input int x, input int y);
    if (pattern == 0) return 0;
    return ((x % 5) == (y % 5)) ? 1 : 0;
  endfunction

  // Playfield renderer with one cycle of read latency.
  always @(posedge clk) begin
    pix_top <= rend_top(int'(pix_x), int'(pix_y_top)) != 0;
    pix_bot <= rend_bot(int'(pix_x), int'(pix_y_bot)) != 0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since the first SHIFT cycle of the current run.
  int m_t;
  bit m_run;
  bit m_fd;
  int m_ra;

  always @(posedge clk or negedge rst_n) begin : model
    int o, tn;
    bit rn;
    if (!rst_n) begin
      m_run <= 1'b0;
      m_t   <= 0;
      m_ra  <= 0;
      m_fd  <= 1'b0;
    end else begin
      o  = m_t % ROW_LEN;
      tn = m_t;
      rn = m_run;
      if (!m_run) begin
        if (enable) begin
          rn = 1'b1;
          tn = 0;
        end
      end else if (o == ROW_LEN - 1) begin
        if (enable) tn = m_t + 1;
        else rn = 1'b0;
      end else begin
        tn = m_t + 1;
      end
      m_fd <= m_run && (o == ROW_LEN - 1) && ((m_t / ROW_LEN) % ROW_PAIRS == ROW_PAIRS - 1);
      if (rn && (tn % ROW_LEN == SHIFT_LEN)) m_ra <= (tn / ROW_LEN) % ROW_PAIRS;
      m_run <= rn;
      m_t   <= tn;
    end
  end

  logic fd_prev = 1'b0;

  always @(negedge clk) begin : compare
    int o, r, c;
    bit e_oe, e_lat, e_sclk;
    if (rst_n) begin
      o = m_t % ROW_LEN;
      r = (m_t / ROW_LEN) % ROW_PAIRS;
      c = o / PH;
      if (m_run) begin
        e_oe   = (o < DISP0);
        e_lat  = (o == LAT_O);
        e_sclk = (o < SHIFT_LEN) && ((o % PH) >= CLK_DIV);
      end else begin
        e_oe   = 1'b1;
        e_lat  = 1'b0;
        e_sclk = 1'b0;
      end
      chk("oe_n", int'(oe_n), int'(e_oe));
      chk("lat", int'(lat), int'(e_lat));
      chk("sclk", int'(sclk), int'(e_sclk));
      chk("frame_done", int'(frame_done), int'(m_fd));
      chk("row_addr", int'(row_addr), m_ra);
      chk("lat_sclk_excl", int'(lat & sclk), 0);
      chk("fd_width", int'(frame_done & fd_prev), 0);
      if (m_run && o < SHIFT_LEN) begin
        chk("pix_x", int'(pix_x), c);
        chk("pix_y_top", int'(pix_y_top), r);
        chk("pix_y_bot", int'(pix_y_bot), r + ROW_PAIRS);
        if ((o % PH) >= CLK_DIV) begin
          chk("r_top", int'(r_top), rend_top(c, r));
          chk("r_bot", int'(r_bot), rend_bot(c, r + ROW_PAIRS));
        end
      end
    end
    fd_prev <= frame_done;
  end

  // Per-row measurement, starting at the negedge of a row's first SHIFT cycle.
  int mr_first, mr_rises, mr_lat, mr_on, mr_rtop, mr_rtop_idx, mr_rbot, mr_ra, mr_len, mr_fd;

  task automatic measure_row(input int drop_at);
    bit prev_s;
    bit done;
    int i;
    prev_s = 1'b0;
    done   = 1'b0;
    i      = 0;
    mr_first = -1; mr_rises = 0; mr_lat = 0; mr_on = 0; mr_rtop = 0;
    mr_rtop_idx = -1; mr_rbot = 0; mr_ra = -1; mr_len = -1; mr_fd = -1;
    while (i < 600 && !done) begin
      if (i == drop_at) enable = 1'b0;
      if (sclk && !prev_s) begin
        mr_rises++;
        if (mr_rises == 1) mr_first = i;
        if (r_top) begin
          mr_rtop++;
          mr_rtop_idx = mr_rises;
        end
        if (r_bot) mr_rbot++;
      end
      prev_s = sclk;
      if (lat) mr_lat++;
      if (!oe_n) begin
        mr_on++;
        mr_ra = int'(row_addr);
      end
      if (mr_on > 0 && oe_n) begin
        done   = 1'b1;
        mr_len = i;
        mr_fd  = int'(frame_done);
      end else begin
        @(negedge clk);
        i++;
      end
    end
    chk("row_ends", int'(done), 1);
  endtask

  task automatic check_row(input int r);
    chk("disp_row_addr", mr_ra, r);
    chk("on_cycles", mr_on, 256);
    chk("lat_cycles", mr_lat, 1);
    chk("sclk_rises", mr_rises, 64);
    chk("row_len", mr_len, 517);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    int lows;
    int highs;
    int k;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", int'(oe_n), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_lat", int'(lat), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_row_addr", int'(row_addr), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_r_top", int'(r_top), 0);
    chk("rst_r_bot", int'(r_bot), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full frame with enable held, single lit pixel at (14, 1).
    enable = 1'b1;
    @(negedge clk);
    total = 0;
    for (int r = 0; r < ROW_PAIRS; r++) begin
      measure_row(-1);
      check_row(r);
      chk("frame_done_at_row_end", mr_fd, (r == ROW_PAIRS - 1) ? 1 : 0);
      total += mr_len;
      if (r == 0) begin
        chk("first_sclk_rise", mr_first, 2);
        chk("row0_rtop_ones", mr_rtop, 0);
      end
      if (r == 1) begin
        chk("row1_rtop_ones", mr_rtop, 1);
        chk("row1_rtop_rise_idx", mr_rtop_idx, 15);
        chk("row1_rbot_ones", mr_rbot, 0);
      end
    end
    chk("frame_period", total, 16544);

    // Second frame with a denser pattern; enable dropped 10 cycles into row 5.
    pattern = 1;
    for (int r = 0; r <= 5; r++) begin
      measure_row((r == 5) ? 10 : -1);
      check_row(r);
      chk("frame_done_mid", mr_fd, 0);
    end
    lows  = 0;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (!oe_n) lows++;
      if (sclk) highs++;
    end
    chk("idle_oe_low_cycles", lows, 0);
    chk("idle_sclk_cycles", highs, 0);

    enable = 1'b1;
    @(negedge clk);
    for (int r = 0; r <= 6; r++) begin
      measure_row(-1);
      check_row(r);
      if (r == 0) chk("restart_first_rise", mr_first, 2);
    end

    // Asynchronous reset in the middle of row 7's on-time.
    k = 0;
    while (oe_n && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("row7_in_display", int'(oe_n), 0);
    repeat (50) @(negedge clk);
    chk("row7_addr_before_rst", int'(row_addr), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe_n", int'(oe_n), 1);
    chk("async_rst_row_addr", int'(row_addr), 0);
    chk("async_rst_lat", int'(lat), 0);
    chk("async_rst_sclk", int'(sclk), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    measure_row(-1);
    check_row(0);
    chk("post_rst_first_rise", mr_first, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
